pdm_spkr_drv: RTL and testbench



---
 rtl/pdm_spkr_drv.sv | 170 +++++++++++++++++
 tb/tb_pdm_spkr_drv.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_spkr_drv.sv
// pdm_spkr_drv: stereo first-order sigma-delta PDM speaker driver.
// Takes signed 16-bit L/R samples, emits complementary PDM pairs for an H-bridge and
// falls back to a 50% duty (silence) when the sample stream stalls.
// Optional build macro PDM_DEADTIME_EN: on every PDM level change both bridge legs are
// held low for one clk before the new level is driven.
module pdm_spkr_drv #(
    parameter int unsigned DIV           = 4,
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [15:0] lft_in,
    input  logic [15:0] rght_in,
    output logic        lft_PDM,
    output logic        lft_PDM_n,
    output logic        rght_PDM,
    output logic        rght_PDM_n,
    output logic        muted,
    output logic        ovr
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StMute} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [DivW-1:0] r_div_cnt;
    logic [ToW-1:0]  r_to_cnt;
    logic [ToW-1:0]  w_to_nxt;
    logic            w_tick;
    logic            w_run;

    logic [15:0] r_hold_l, r_hold_r;
    logic [15:0] r_act_l, r_act_r;
    logic [15:0] r_acc_l, r_acc_r;
    logic        r_pend;
    logic        r_pdm_l, r_pdm_r;
    logic        r_ovr;
    logic        w_gap_l, w_gap_r;

    logic [15:0] w_u_l, w_u_r;
    logic [15:0] w_src_l, w_src_r;
    logic [15:0] w_eff_l, w_eff_r;
    logic [16:0] w_sum_l, w_sum_r;

    // Offset-binary conversion, source selection and the 17-bit accumulator sums.
    always_comb begin
        w_tick  = (r_div_cnt == DivLast);
        w_run   = (r_state != StIdle);
        w_u_l   = {~lft_in[15], lft_in[14:0]};
        w_u_r   = {~rght_in[15], rght_in[14:0]};
        w_src_l = r_pend ? r_hold_l : r_act_l;
        w_src_r = r_pend ? r_hold_r : r_act_r;
        w_eff_l = (r_state == StMute) ? 16'h8000 : w_src_l;
        w_eff_r = (r_state == StMute) ? 16'h8000 : w_src_r;
        w_sum_l = {1'b0, r_acc_l} + {1'b0, w_eff_l};
        w_sum_r = {1'b0, r_acc_r} + {1'b0, w_eff_r};
    end

    // Next-state logic; the stall counter only runs in StRun and any vld restarts it.
    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to_cnt;
        if (vld || (r_state != StRun)) begin
            w_to_nxt = '0;
        end else if (w_tick) begin
            w_to_nxt = r_to_cnt + ToW'(1);
        end
        case (r_state)
            StIdle:  if (vld) w_state_nxt = StRun;
            StRun:   if (!vld && w_tick && (r_to_cnt == ToLast)) w_state_nxt = StMute;
            StMute:  if (vld) w_state_nxt = StRun;
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tick divider: one PDM update every DIV clocks, tick on the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DivW'(1);
        end
    end

    // Sample capture, per-tick modulator update, overwrite flag and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_act_l  <= '0;
            r_act_r  <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_pdm_l  <= 1'b0;
            r_pdm_r  <= 1'b0;
            r_pend   <= 1'b0;
            r_ovr    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (vld) begin
                r_hold_l <= w_u_l;
                r_hold_r <= w_u_r;
            end
            if (w_tick) begin
                r_act_l <= w_src_l;
                r_act_r <= w_src_r;
                // Accumulators stay frozen at zero until the first sample arrives.
                if (w_run) begin
                    r_acc_l <= w_sum_l[15:0];
                    r_acc_r <= w_sum_r[15:0];
                    r_pdm_l <= w_sum_l[16];
                    r_pdm_r <= w_sum_r[16];
                end
            end
            // A tick in the same cycle consumes the old hold, so the new one stays pending.
            r_pend   <= vld | (r_pend & ~w_tick);
            r_ovr    <= vld & r_pend & ~w_tick;
            r_to_cnt <= w_to_nxt;
        end
    end

`ifdef PDM_DEADTIME_EN
    logic r_gap_l, r_gap_r;

    // Break-before-make: flag the one clk following a tick that flips a PDM level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_l <= 1'b0;
            r_gap_r <= 1'b0;
        end else begin
            r_gap_l <= w_tick & w_run & (w_sum_l[16] != r_pdm_l);
            r_gap_r <= w_tick & w_run & (w_sum_r[16] != r_pdm_r);
        end
    end

    assign w_gap_l = r_gap_l;
    assign w_gap_r = r_gap_r;
`else
    assign w_gap_l = 1'b0;
    assign w_gap_r = 1'b0;
`endif

    // Bridge drive: both legs off in StIdle and during a dead-time gap.
    always_comb begin
        lft_PDM    = w_run & ~w_gap_l & r_pdm_l;
        lft_PDM_n  = w_run & ~w_gap_l & ~r_pdm_l;
        rght_PDM   = w_run & ~w_gap_r & r_pdm_r;
        rght_PDM_n = w_run & ~w_gap_r & ~r_pdm_r;
        muted      = (r_state == StMute);
        ovr        = r_ovr;
    end

endmodule

// File: tb/tb_pdm_spkr_drv.sv
// Directed self-checking bench for pdm_spkr_drv (DIV=4, short stall timeout).
// Sampling happens on negedges; cnt_m tracks the divider phase from the reset edge.
module tb_pdm_spkr_drv;

    localparam int unsigned DIV = 4;
    localparam int unsigned TO  = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [15:0] lft_in;
    logic [15:0] rght_in;
    logic        lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr;

    int checks = 0;
    int errors = 0;
    int cnt_m  = 0;

    always #5 clk = ~clk;

    pdm_spkr_drv #(
        .DIV           (DIV),
        .TIMEOUT_TICKS (TO)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .vld        (vld),
        .lft_in     (lft_in),
        .rght_in    (rght_in),
        .lft_PDM    (lft_PDM),
        .lft_PDM_n  (lft_PDM_n),
        .rght_PDM   (rght_PDM),
        .rght_PDM_n (rght_PDM_n),
        .muted      (muted),
        .ovr        (ovr)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        cnt_m = (cnt_m + 1) % DIV;
    endtask

    // Advance past exactly one tick edge and stop at the negedge where the count is 1.
    task automatic next_tick();
        bit seen = 1'b0;
        while (!(seen && cnt_m == 1)) begin
            if (cnt_m == DIV - 1) seen = 1'b1;
            step();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        vld = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        cnt_m = 0;
    endtask

    task automatic vld_pulse(input logic [15:0] l, input logic [15:0] r);
        vld     = 1'b1;
        lft_in  = l;
        rght_in = r;
        step();
        vld = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_now: got %b required 000000",
                     {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr});
        end
        for (int i = 0; i < 50; i++) begin
            next_tick();
            checks++;
            if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle tick %0d: got %b required 000000", i,
                         {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr});
            end
        end
    endtask

    // 0x0000 -> 50% duty on left; 0x8000 -> constant 0 on right.
    task automatic test_half_duty();
        logic [3:0] exp;
        vld_pulse(16'h0000, 16'h8000);
        for (int i = 0; i < 64; i++) begin
            if (i > 0 && i % 32 == 0) vld_pulse(16'h0000, 16'h8000);
            next_tick();
            exp = {(i % 2 == 1), (i % 2 == 0), 1'b0, 1'b1};
            checks++;
            if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n} !== exp) begin
                errors++;
                $display("FAIL half_duty tick %0d: got %b required %b", i,
                         {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n}, exp);
            end
        end
    endtask

    // 0x4000 -> repeating 0,1,1,1.
    task automatic test_quarter();
        logic exp;
        reset_dut();
        vld_pulse(16'h4000, 16'h4000);
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && i % 8 == 0) vld_pulse(16'h4000, 16'h4000);
            next_tick();
            exp = (i % 4 != 0);
            checks++;
            if ({lft_PDM, rght_PDM} !== {exp, exp}) begin
                errors++;
                $display("FAIL quarter tick %0d: got %b required %b", i,
                         {lft_PDM, rght_PDM}, {exp, exp});
            end
        end
    endtask

    // 0x7FFF -> single 0 on the first tick, then 1s.
    task automatic test_full_scale();
        logic exp;
        reset_dut();
        vld_pulse(16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 12; i++) begin
            next_tick();
            exp = (i != 0);
            checks++;
            if ({lft_PDM, rght_PDM} !== {exp, exp}) begin
                errors++;
                $display("FAIL full_scale tick %0d: got %b required %b", i,
                         {lft_PDM, rght_PDM}, {exp, exp});
            end
        end
    endtask

    // Back-to-back strobes with no tick between: one ovr pulse, second sample plays.
    task automatic test_back_to_back();
        reset_dut();
        vld_pulse(16'h8000, 16'h8000);
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got %b required 0", ovr);
        end
        vld_pulse(16'h0000, 16'h0000);
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse: got %b required 1", ovr);
        end
        step();
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drop: got %b required 0", ovr);
        end
        next_tick();
        checks++;
        if (lft_PDM !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tick0: got %b required 0", lft_PDM);
        end
        next_tick();
        checks++;
        if (lft_PDM !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tick1: got %b required 1", lft_PDM);
        end
    endtask

    // vld coinciding with a tick: old hold consumed, new stays pending, no ovr.
    task automatic test_simultaneous();
        reset_dut();
        vld_pulse(16'h8000, 16'h8000);
        while (cnt_m != DIV - 1) step();
        vld_pulse(16'h0000, 16'h0000);
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL simul_ovr: got %b required 0", ovr);
        end
        step();
        checks++;
        if ({lft_PDM, lft_PDM_n} !== 2'b01) begin
            errors++;
            $display("FAIL simul_tick0: got %b required 01", {lft_PDM, lft_PDM_n});
        end
        next_tick();
        checks++;
        if (lft_PDM !== 1'b0) begin
            errors++;
            $display("FAIL simul_tick1: got %b required 0", lft_PDM);
        end
        next_tick();
        checks++;
        if (lft_PDM !== 1'b1) begin
            errors++;
            $display("FAIL simul_tick2: got %b required 1", lft_PDM);
        end
    endtask

    // Stall -> MUTE after TO ticks, 50% duty, recovery on vld, then mid-stream reset.
    task automatic test_timeout();
        logic [15:0] acc;
        logic [16:0] sum;
        logic        exp_mute;
        acc = '0;
        reset_dut();
        vld_pulse(16'h4000, 16'h8000);
        for (int k = 1; k <= int'(TO) + 8; k++) begin
            next_tick();
            sum      = {1'b0, acc} + ((k <= int'(TO)) ? 17'h0C000 : 17'h08000);
            acc      = sum[15:0];
            exp_mute = (k >= int'(TO));
            checks++;
            if ({muted, lft_PDM} !== {exp_mute, sum[16]}) begin
                errors++;
                $display("FAIL timeout tick %0d: got muted,pdm=%b required %b", k,
                         {muted, lft_PDM}, {exp_mute, sum[16]});
            end
        end
        vld_pulse(16'h4000, 16'h8000);
        checks++;
        if (muted !== 1'b0) begin
            errors++;
            $display("FAIL unmute: got %b required 0", muted);
        end
        for (int k = 0; k < 8; k++) begin
            next_tick();
            sum = {1'b0, acc} + 17'h0C000;
            acc = sum[15:0];
            checks++;
            if ({muted, lft_PDM} !== {1'b0, sum[16]}) begin
                errors++;
                $display("FAIL resume tick %0d: got muted,pdm=%b required %b", k,
                         {muted, lft_PDM}, {1'b0, sum[16]});
            end
        end
        step();
        reset_dut();
        checks++;
        if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b required 000000",
                     {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted, ovr});
        end
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++;
            if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted} !== 5'b0) begin
                errors++;
                $display("FAIL post_reset_idle tick %0d: got %b required 00000", i,
                         {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, muted});
            end
        end
    endtask

    // Output levels in the cycle right after each tick edge, and the settled level after.
    task automatic test_gap();
        logic c;
        logic [1:0] exp_edge;
        reset_dut();
        vld_pulse(16'h0000, 16'h8000);
        for (int k = 1; k <= 8; k++) begin
            step();
            while (cnt_m != 0) step();
            c = (k % 2 == 0);
`ifdef PDM_DEADTIME_EN
            exp_edge = (k >= 2) ? 2'b00 : {c, ~c};
`else
            exp_edge = {c, ~c};
`endif
            checks++;
            if ({lft_PDM, lft_PDM_n} !== exp_edge) begin
                errors++;
                $display("FAIL gap_edge tick %0d: got %b required %b", k,
                         {lft_PDM, lft_PDM_n}, exp_edge);
            end
            step();
            checks++;
            if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n} !== {c, ~c, 2'b01}) begin
                errors++;
                $display("FAIL gap_settle tick %0d: got %b required %b", k,
                         {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n}, {c, ~c, 2'b01});
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        vld     = 1'b0;
        lft_in  = '0;
        rght_in = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_half_duty();
        test_quarter();
        test_full_scale();
        test_back_to_back();
        test_simultaneous();
        test_timeout();
        test_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
